// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the subleq core: 1-cycle registered write-first
// word RAM, with a valid/ready loader port that owns the RAM while the core
// is held in reset.
module subleq_mem_responder #(
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned DEPTH         = 8192,
    parameter bit          LOAD_ON_RESET = 1'b1,
    parameter int unsigned RELEASE_CYC   = 2
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [DATA_W-1:0] iData,
    input  logic              iWren,
    output logic [DATA_W-1:0] oQ,
    input  logic              iLoadMode,
    input  logic              iLoadValid,
    output logic              oLoadReady,
    input  logic [ADDR_W-1:0] iLoadAddr,
    input  logic [DATA_W-1:0] iLoadData,
    output logic              oCpuHold,
    output logic [ADDR_W:0]   oLoadCount,
    output logic              oErr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam state_t RESET_STATE = LOAD_ON_RESET ? S_LOAD : S_RUN;

    state_t             state;
    state_t             state_next;
    logic [REL_W-1:0]   relcnt;
    logic [REL_W-1:0]   relcnt_next;
    logic               hold_next;
    logic               ready_next;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               core_ok;
    logic               load_ok;
    logic               core_wr;
    logic               load_wr;
    logic               load_beat;
    logic [IDX_W-1:0]   core_idx;
    logic [IDX_W-1:0]   load_idx;

    // Address range decode and access qualification
    always_comb begin
        core_ok   = 32'(iAddress) < DEPTH;
        load_ok   = 32'(iLoadAddr) < DEPTH;
        core_idx  = IDX_W'(iAddress);
        load_idx  = IDX_W'(iLoadAddr);
        load_beat = (state == S_LOAD) && iLoadValid;
        core_wr   = (state == S_RUN) && iWren && core_ok;
        load_wr   = load_beat && load_ok;
    end

    // Ownership FSM state, release counter and state-decoded control outputs
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state      <= RESET_STATE;
            relcnt     <= '0;
            oCpuHold   <= LOAD_ON_RESET;
            oLoadReady <= LOAD_ON_RESET;
        end else begin
            state      <= state_next;
            relcnt     <= relcnt_next;
            oCpuHold   <= hold_next;
            oLoadReady <= ready_next;
        end
    end

    // Next state; hold/ready are decoded from the next state so the
    // registered outputs always equal a pure decode of the current state
    always_comb begin
        state_next  = state;
        relcnt_next = relcnt;
        hold_next   = 1'b1;
        ready_next  = 1'b0;
        case (state)
            S_RUN: begin
                if (iLoadMode) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!iLoadMode) begin
                    state_next  = S_RELEASE;
                    relcnt_next = '0;
                end
            end
            S_RELEASE: begin
                if (iLoadMode) begin
                    state_next  = S_LOAD;
                    relcnt_next = '0;
                end else if (32'(relcnt) + 32'd1 >= RELEASE_CYC) begin
                    state_next  = S_RUN;
                    relcnt_next = '0;
                end else begin
                    relcnt_next = relcnt + 1'b1;
                end
            end
            default: begin
                state_next  = RESET_STATE;
                relcnt_next = '0;
            end
        endcase
        hold_next  = (state_next != S_RUN);
        ready_next = (state_next == S_LOAD);
    end

    // Word RAM write port; contents survive reset
    always_ff @(posedge iClock) begin
        if (core_wr) begin
            mem[core_idx] <= iData;
        end else if (load_wr) begin
            mem[load_idx] <= iLoadData;
        end
    end

    // Registered write-first read; holds while the loader owns the RAM
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oQ <= '0;
        end else if (state == S_RUN) begin
            if (!core_ok) begin
                oQ <= '0;
            end else if (iWren) begin
                oQ <= iData;
            end else begin
                oQ <= mem[core_idx];
            end
        end
    end

    // Saturating loader beat counter; out-of-range beats still count
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oLoadCount <= '0;
        end else if (load_beat && !oLoadCount[ADDR_W]) begin
            oLoadCount <= oLoadCount + 1'b1;
        end
    end

    // Sticky out-of-range access flag
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oErr <= 1'b0;
        end else if (((state == S_RUN) && !core_ok) || (load_beat && !load_ok)) begin
            oErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_subleq_mem_responder.sv
// Directed bench for subleq_mem_responder: a full-depth instance and a
// DEPTH=4096 instance share stimulus, checked against hand-computed vectors.
module tb_subleq_mem_responder;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 64;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic              load_mode;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    logic [DATA_W-1:0] q;
    logic              ready;
    logic              hold;
    logic [ADDR_W:0]   cnt;
    logic              err;

    logic [DATA_W-1:0] q4;
    logic              ready4;
    logic              hold4;
    logic [ADDR_W:0]   cnt4;
    logic              err4;

    int tests;
    int fails;

    subleq_mem_responder dut (
        .iClock(clk), .iReset_n(rst_n), .iAddress(addr), .iData(data), .iWren(wren),
        .oQ(q), .iLoadMode(load_mode), .iLoadValid(load_valid), .oLoadReady(ready),
        .iLoadAddr(load_addr), .iLoadData(load_data), .oCpuHold(hold),
        .oLoadCount(cnt), .oErr(err)
    );

    subleq_mem_responder #(.DEPTH(4096)) dut4 (
        .iClock(clk), .iReset_n(rst_n), .iAddress(addr), .iData(data), .iWren(wren),
        .oQ(q4), .iLoadMode(load_mode), .iLoadValid(load_valid), .oLoadReady(ready4),
        .iLoadAddr(load_addr), .iLoadData(load_data), .oCpuHold(hold4),
        .oLoadCount(cnt4), .oErr(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              lm;
        logic              lv;
        logic [ADDR_W-1:0] la;
        logic [DATA_W-1:0] ld;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              we;
        logic              e_hold;
        logic              e_ready;
        logic [ADDR_W:0]   e_cnt;
        logic [DATA_W-1:0] e_q;
        logic [DATA_W-1:0] e_q4;
        logic              e_err;
        logic              e_err4;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lm, input logic lv, input logic [ADDR_W-1:0] la,
                         input logic [DATA_W-1:0] ld, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic we);
        load_mode  = lm;
        load_valid = lv;
        load_addr  = la;
        load_data  = ld;
        addr       = a;
        data       = d;
        wren       = we;
    endtask

    localparam logic [DATA_W-1:0] W0 = 64'h0000_0003_0001_0002;
    localparam logic [DATA_W-1:0] WF = 64'hFFFF_FFFF_FFFF_FFFE;

    initial begin
        tests = 0;
        fails = 0;

        //           lm    lv    la         ld       a          d         we    hold  rdy   cnt     q        q4       err   err4
        vecs[0]  = '{1'b1, 1'b1, 13'h0,    W0,      13'h0,    64'h0,    1'b0, 1'b1, 1'b1, 14'd1, 64'h0,   64'h0,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 13'h1,    64'd5,   13'h0,    64'h0,    1'b0, 1'b1, 1'b1, 14'd2, 64'h0,   64'h0,   1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 13'h2,    64'd7,   13'h0,    64'h0,    1'b0, 1'b1, 1'b0, 14'd3, 64'h0,   64'h0,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b1, 1'b0, 14'd3, 64'h0,   64'h0,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b0, 1'b0, 14'd3, 64'h0,   64'h0,   1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b0, 1'b0, 14'd3, 64'd5,   64'd5,   1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h2,    WF,       1'b1, 1'b0, 1'b0, 14'd3, WF,      WF,      1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h0,    64'h0,    1'b0, 1'b0, 1'b0, 14'd3, W0,      W0,      1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h2,    64'h0,    1'b0, 1'b0, 1'b0, 14'd3, WF,      WF,      1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1000, 64'hDEAD, 1'b1, 1'b0, 1'b0, 14'd3, 64'hDEAD, 64'h0,  1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1000, 64'h0,    1'b0, 1'b0, 1'b0, 14'd3, 64'hDEAD, 64'h0,  1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h0,    64'h0,    1'b0, 1'b0, 1'b0, 14'd3, W0,      W0,      1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 13'h3,    64'hAA,  13'h1,    64'h55,   1'b1, 1'b1, 1'b1, 14'd3, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 13'h0,    64'h0,   13'h1,    64'h66,   1'b1, 1'b1, 1'b1, 14'd3, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 13'h1FFF, 64'h99,  13'h1,    64'h0,    1'b0, 1'b1, 1'b1, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b1, 1'b0, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b1, 1'b0, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b1, 1'b1, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b1, 1'b0, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b1, 1'b0, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b0, 1'b0, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h2,    64'h0,    1'b0, 1'b0, 1'b0, 14'd4, WF,      WF,      1'b0, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1,    64'h0,    1'b0, 1'b0, 1'b0, 14'd4, 64'h55,  64'h55,  1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h1FFF, 64'h0,    1'b0, 1'b0, 1'b0, 14'd4, 64'h99,  64'h0,   1'b0, 1'b1};
        vecs[24] = '{1'b0, 1'b1, 13'h2,    64'h77,  13'h0,    64'h0,    1'b0, 1'b0, 1'b0, 14'd4, W0,      W0,      1'b0, 1'b1};
        vecs[25] = '{1'b0, 1'b0, 13'h0,    64'h0,   13'h2,    64'h0,    1'b0, 1'b0, 1'b0, 14'd4, WF,      WF,      1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        step();
        step();
        chk("reset_hold",  64'(hold),  64'd1);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_q",     q,          64'h0);
        chk("reset_err",   64'(err),   64'd0);
        chk("reset_cnt",   64'(cnt),   64'd0);
        rst_n = 1'b1;

        // Table: load, release timing, reads, write-first, range errors, load re-entry
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].lm, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].a, vecs[i].d, vecs[i].we);
            step();
            chk($sformatf("v%0d_hold", i),   64'(hold),   64'(vecs[i].e_hold));
            chk($sformatf("v%0d_ready", i),  64'(ready),  64'(vecs[i].e_ready));
            chk($sformatf("v%0d_cnt", i),    64'(cnt),    64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_q", i),      q,           vecs[i].e_q);
            chk($sformatf("v%0d_err", i),    64'(err),    64'(vecs[i].e_err));
            chk($sformatf("v%0d_hold4", i),  64'(hold4),  64'(vecs[i].e_hold));
            chk($sformatf("v%0d_ready4", i), 64'(ready4), 64'(vecs[i].e_ready));
            chk($sformatf("v%0d_cnt4", i),   64'(cnt4),   64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_q4", i),     q4,          vecs[i].e_q4);
            chk($sformatf("v%0d_err4", i),   64'(err4),   64'(vecs[i].e_err4));
        end

        // Reset in the middle of a load: control clears, RAM keeps contents
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        step();
        drive(1'b1, 1'b1, 13'h5, 64'h123, '0, '0, 1'b0);
        step();
        chk("midload_cnt", 64'(cnt), 64'd5);
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_hold",  64'(hold),  64'd1);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_cnt",   64'(cnt),   64'd0);
        chk("rst_q",     q,          64'h0);
        chk("rst_err4",  64'(err4),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        step();
        step();
        chk("rst_rel_hold", 64'(hold), 64'd1);
        step();
        chk("rst_run_hold", 64'(hold), 64'd0);
        drive(1'b0, 1'b0, '0, '0, 13'h5, '0, 1'b0);
        step();
        chk("retained_5", q, 64'h123);
        drive(1'b0, 1'b0, '0, '0, 13'h0, '0, 1'b0);
        step();
        chk("retained_0", q, W0);
        chk("retained_0_4k", q4, W0);

        // Loader counter saturates at 2**ADDR_W
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        step();
        for (int i = 0; i < 8192; i++) begin
            drive(1'b1, 1'b1, 13'h4, 64'(i), '0, '0, 1'b0);
            step();
        end
        chk("sat_cnt_at", 64'(cnt), 64'd8192);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("sat_cnt_held",  64'(cnt),  64'd8192);
        chk("sat_cnt4_held", 64'(cnt4), 64'd8192);
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
